// File: rtl/epp_bridge_fifo.sv
// epp_bridge_fifo
// ---------------------------------------------------------------------------
// Digilent EPP slave bridge. The host reaches three windows through the EPP
// data strobe: an RX FIFO (host -> machine), a TX FIFO (machine -> host) and
// a STATUS register. All other addresses become a handshaked machine-bus
// cycle. The address register is loaded and read with the address strobe.
//
// Optional feature: define EPP_BRIDGE_TIMEOUT_EN to abort bus cycles that see
// no bus_ack within TIMEOUT clocks. An aborted read returns 0xFF and sets
// STATUS bit5. Without the macro a bus cycle waits for ack indefinitely.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   usb_write                 EPP direction (0 = host write)
//   usb_astb, usb_dstb        EPP address / data strobes, active low
//   usb_db_i / usb_db_o       EPP data from / to the pad
//   usb_db_oe, usb_wait       pad output enable, EPP wait
//   bus_addr, bus_wdata       machine bus address and write data
//   bus_rdata, bus_ack        machine bus read data and one-cycle completion
//   bus_read, bus_write       level bus requests, held until ack
//   rx_data, rx_empty, rx_pop RX FIFO consumer side
//   tx_data, tx_push, tx_full TX FIFO producer side
//
// Handshake: the host asserts a strobe; the bridge drives usb_wait high once
// the access is complete (read data valid on usb_db_o with usb_db_oe high),
// and drops usb_wait after both strobes are released.
// ---------------------------------------------------------------------------
module epp_bridge_fifo #(
    parameter int ADDR_W      = 8,
    parameter int RX_DEPTH    = 64,
    parameter int TX_DEPTH    = 64,
    parameter int RX_ADDR     = 0,
    parameter int TX_ADDR     = 0,
    parameter int STAT_ADDR   = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              usb_write,
    input  logic              usb_astb,
    input  logic              usb_dstb,
    input  logic [7:0]        usb_db_i,
    output logic [7:0]        usb_db_o,
    output logic              usb_db_oe,
    output logic              usb_wait,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    output logic              bus_read,
    output logic              bus_write,
    input  logic              bus_ack,
    output logic [7:0]        rx_data,
    output logic              rx_empty,
    input  logic              rx_pop,
    input  logic [7:0]        tx_data,
    input  logic              tx_push,
    output logic              tx_full
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0]    RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0]    TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [ADDR_W-1:0] RX_A   = ADDR_W'(RX_ADDR);
    localparam logic [ADDR_W-1:0] TX_A   = ADDR_W'(TX_ADDR);
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(STAT_ADDR);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_BUS, ST_HOLD} state_t;
    state_t state;

    // Strobe / direction synchronisers, idle-high so reset looks like "no strobe".
    logic [SYNC_STAGES-1:0] astb_sync, dstb_sync, write_sync;
    logic asa, dsa, wra;

    always_ff @(posedge clk) begin
        if (rst) begin
            astb_sync  <= '1;
            dstb_sync  <= '1;
            write_sync <= '1;
        end else begin
            astb_sync  <= {astb_sync[SYNC_STAGES-2:0], usb_astb};
            dstb_sync  <= {dstb_sync[SYNC_STAGES-2:0], usb_dstb};
            write_sync <= {write_sync[SYNC_STAGES-2:0], usb_write};
        end
    end

    assign asa = astb_sync[SYNC_STAGES-1];
    assign dsa = dstb_sync[SYNC_STAGES-1];
    assign wra = write_sync[SYNC_STAGES-1];

    // Latched access descriptor
    logic [ADDR_W-1:0] addr_q;
    logic              is_addr_q, is_read_q;
    logic [7:0]        db_q;
    logic              ovf, unf, tmo;

    assign bus_addr = addr_q;

    // FIFO storage and pointers
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [RX_AW-1:0] rx_wr, rx_rd;
    logic [TX_AW-1:0] tx_wr, tx_rd;
    logic [RX_AW:0]   rx_count;
    logic [TX_AW:0]   tx_count;
    logic             rx_full, tx_empty;
    logic [7:0]       tx_head, status;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_FULL_CNT);
    assign rx_data  = rx_mem[rx_rd];
    assign tx_head  = tx_mem[tx_rd];
    assign status   = {ovf, unf, tmo, 1'b0, tx_full, tx_empty, rx_full, rx_empty};

    // Window decode; a FIFO window wins over STATUS if they share an address.
    logic exec_data, rx_win, tx_win, stat_wr, stat_rd;
    logic rx_do_push, rx_do_pop, tx_do_push, tx_do_pop, flush;

    always_comb begin
        exec_data  = (state == ST_EXEC) && !is_addr_q;
        rx_win     = exec_data && !is_read_q && (addr_q == RX_A);
        tx_win     = exec_data &&  is_read_q && (addr_q == TX_A);
        stat_wr    = exec_data && !is_read_q && (addr_q != RX_A) && (addr_q == STAT_A);
        stat_rd    = exec_data &&  is_read_q && (addr_q != TX_A) && (addr_q == STAT_A);
        flush      = stat_wr && db_q[6];
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        rx_do_push = rx_win && (!rx_full || rx_pop);
        rx_do_pop  = rx_pop && !rx_empty;
        tx_do_pop  = tx_win && !tx_empty;
        tx_do_push = tx_push && (!tx_full || tx_do_pop);
    end

    always_ff @(posedge clk) begin
        if (rx_do_push && !flush) rx_mem[rx_wr] <= db_q;
        if (tx_do_push && !flush) tx_mem[tx_wr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rx_wr <= '0; rx_rd <= '0; rx_count <= '0;
            tx_wr <= '0; tx_rd <= '0; tx_count <= '0;
        end else begin
            if (rx_do_push) rx_wr <= rx_wr + 1'b1;
            if (rx_do_pop)  rx_rd <= rx_rd + 1'b1;
            if (rx_do_push && !rx_do_pop)      rx_count <= rx_count + 1'b1;
            else if (!rx_do_push && rx_do_pop) rx_count <= rx_count - 1'b1;
            if (tx_do_push) tx_wr <= tx_wr + 1'b1;
            if (tx_do_pop)  tx_rd <= tx_rd + 1'b1;
            if (tx_do_push && !tx_do_pop)      tx_count <= tx_count + 1'b1;
            else if (!tx_do_push && tx_do_pop) tx_count <= tx_count - 1'b1;
        end
    end

`ifdef EPP_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    localparam int unused_timeout = TIMEOUT;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            is_addr_q <= 1'b0;
            is_read_q <= 1'b0;
            db_q      <= 8'h00;
            usb_db_o  <= 8'h00;
            usb_db_oe <= 1'b0;
            usb_wait  <= 1'b1;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_wdata <= 8'h00;
            ovf       <= 1'b0;
            unf       <= 1'b0;
`ifdef EPP_BRIDGE_TIMEOUT_EN
            tmo       <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    usb_wait  <= 1'b0;
                    usb_db_oe <= 1'b0;
                    if (!asa || !dsa) begin
                        is_addr_q <= !asa;
                        is_read_q <= wra;
                        db_q      <= usb_db_i;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state     <= ST_HOLD;
                    usb_wait  <= 1'b1;
                    usb_db_oe <= is_read_q;
`ifdef EPP_BRIDGE_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                    if (is_addr_q) begin
                        if (is_read_q) usb_db_o <= 8'(addr_q);
                        else           addr_q   <= db_q[ADDR_W-1:0];
                    end else if (rx_win) begin
                        if (!rx_do_push) ovf <= 1'b1;
                    end else if (tx_win) begin
                        usb_db_o <= tx_empty ? 8'h00 : tx_head;
                        if (tx_empty) unf <= 1'b1;
                    end else if (stat_rd) begin
                        usb_db_o <= status;
                    end else if (stat_wr) begin
                        if (db_q[7]) begin
                            ovf <= 1'b0;
                            unf <= 1'b0;
`ifdef EPP_BRIDGE_TIMEOUT_EN
                            tmo <= 1'b0;
`endif
                        end
                    end else begin
                        // Any other address becomes a machine-bus cycle.
                        state     <= ST_BUS;
                        usb_wait  <= 1'b0;
                        usb_db_oe <= 1'b0;
                        if (is_read_q) begin
                            bus_read <= 1'b1;
                        end else begin
                            bus_write <= 1'b1;
                            bus_wdata <= db_q;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_ack) begin
                        if (bus_read) usb_db_o <= bus_rdata;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        usb_wait  <= 1'b1;
                        usb_db_oe <= is_read_q;
                        state     <= ST_HOLD;
                    end
`ifdef EPP_BRIDGE_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        if (bus_read) usb_db_o <= 8'hFF;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        tmo       <= 1'b1;
                        usb_wait  <= 1'b1;
                        usb_db_oe <= is_read_q;
                        state     <= ST_HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (asa && dsa) begin
                        usb_wait  <= 1'b0;
                        usb_db_oe <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_epp_bridge_fifo.sv
// Bench for epp_bridge_fifo: host EPP driver tasks, consumer/producer tasks,
// a machine-bus responder, and monitors that pop expected values from queues.
module tb_epp_bridge_fifo;

    localparam int RXD   = 8;
    localparam int TXD   = 4;
    localparam int SYNC  = 2;
    localparam int TMO   = 10;
    localparam int LIMIT = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       usb_write, usb_astb, usb_dstb;
    logic [7:0] usb_db_i, usb_db_o;
    logic       usb_db_oe, usb_wait;
    logic [7:0] bus_addr, bus_wdata, bus_rdata;
    logic       bus_read, bus_write, bus_ack;
    logic [7:0] rx_data, tx_data;
    logic       rx_empty, rx_pop, tx_push, tx_full;

    always #5 clk = ~clk;

    epp_bridge_fifo #(
        .ADDR_W(8), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .RX_ADDR(0), .TX_ADDR(0),
        .STAT_ADDR(1), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .usb_write(usb_write), .usb_astb(usb_astb),
        .usb_dstb(usb_dstb), .usb_db_i(usb_db_i), .usb_db_o(usb_db_o),
        .usb_db_oe(usb_db_oe), .usb_wait(usb_wait), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_read(bus_read),
        .bus_write(bus_write), .bus_ack(bus_ack), .rx_data(rx_data),
        .rx_empty(rx_empty), .rx_pop(rx_pop), .tx_data(tx_data),
        .tx_push(tx_push), .tx_full(tx_full)
    );

    int tests = 0;
    int fails = 0;

    // Scoreboard queues and reference model
    logic [7:0]  exp_q[$];      // expected host read bytes
    logic [7:0]  rx_exp_q[$];   // expected rx_data at each consumer pop
    logic [16:0] bus_exp_q[$];  // {is_write, addr, wdata}
    logic [7:0]  rx_model[$];
    logic [7:0]  tx_model[$];
    logic [7:0]  m_addr = 8'h00;
    bit          m_ovf = 0, m_unf = 0, m_tmo = 0;
    bit          no_ack_mode = 0;
    int          forced_lat = -1;
    int          forced_rdata = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_status();
        return {m_ovf, m_unf, m_tmo, 1'b0,
                tx_model.size() == TXD, tx_model.size() == 0,
                rx_model.size() == RXD, rx_model.size() == 0};
    endfunction

    // ---------------- monitors ----------------
    logic prev_wait = 1'b1;
    always @(negedge clk) begin
        if (!rst && usb_wait && !prev_wait && usb_db_oe) begin
            if (exp_q.size() == 0) check("host_read_unexpected", usb_db_o, 32'hDEAD);
            else check("host_read", usb_db_o, exp_q.pop_front());
        end
        prev_wait = usb_wait;
        if (!rst && rx_pop && !rx_empty) begin
            if (rx_exp_q.size() == 0) check("rx_pop_unexpected", rx_data, 32'hDEAD);
            else check("rx_data", rx_data, rx_exp_q.pop_front());
        end
    end

    // ---------------- bus responder ----------------
    initial begin
        logic [16:0] e;
        int lat, n;
        bus_ack = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && (bus_read || bus_write)) begin
                if (bus_exp_q.size() == 0) begin
                    check("bus_req_unexpected", {bus_read, bus_write}, 0);
                end else begin
                    e = bus_exp_q.pop_front();
                    check("bus_kind", bus_write, e[16]);
                    check("bus_addr", bus_addr, e[15:8]);
                    if (e[16]) check("bus_wdata", bus_wdata, e[7:0]);
                end
                if (no_ack_mode) begin
                    n = 1;
                    repeat (TMO + 20) begin
                        @(negedge clk);
                        if (bus_read || bus_write) n++;
                        else break;
                    end
                    check("bus_timeout_len", n, TMO);
                end else begin
                    lat = (forced_lat >= 0) ? forced_lat : $urandom_range(0, 4);
                    repeat (lat) @(negedge clk);
                    check("bus_req_held", bus_read || bus_write, 1);
                    if (bus_read) begin
                        bus_rdata = (forced_rdata >= 0) ? 8'(forced_rdata) : 8'($urandom);
                        exp_q.push_back(bus_rdata);
                    end
                    bus_ack = 1'b1;
                    @(negedge clk);
                    bus_ack = 1'b0;
                    check("bus_req_dropped", bus_read || bus_write, 0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic host_op(input bit is_addr, input bit is_read, input logic [7:0] d,
                           input bit chk_lat);
        int n;
        @(posedge clk); #1;
        usb_write = is_read;
        usb_db_i  = is_read ? 8'($urandom) : d;
        if (is_addr) usb_astb = 1'b0;
        else         usb_dstb = 1'b0;
        n = 0;
        while (!usb_wait && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_rise", usb_wait, 1);
        if (usb_wait && chk_lat) check("wait_latency", n, SYNC + 2);
        usb_astb = 1'b1;
        usb_dstb = 1'b1;
        n = 0;
        while (usb_wait && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_fall", usb_wait, 0);
    endtask

    task automatic host_addr_write(input logic [7:0] a);
        m_addr = a;
        host_op(1, 0, a, 1);
    endtask

    task automatic host_addr_read();
        exp_q.push_back(m_addr);
        host_op(1, 1, 8'h00, 1);
    endtask

    task automatic host_data_write(input logic [7:0] d);
        if (m_addr == 8'd0) begin
            if (rx_model.size() < RXD) rx_model.push_back(d);
            else m_ovf = 1;
            host_op(0, 0, d, 1);
        end else if (m_addr == 8'd1) begin
            if (d[7]) begin m_ovf = 0; m_unf = 0; m_tmo = 0; end
            if (d[6]) begin rx_model.delete(); tx_model.delete(); end
            host_op(0, 0, d, 1);
        end else begin
            bus_exp_q.push_back({1'b1, m_addr, d});
            host_op(0, 0, d, 0);
        end
    endtask

    task automatic host_data_read();
        if (m_addr == 8'd0) begin
            if (tx_model.size() > 0) exp_q.push_back(tx_model.pop_front());
            else begin exp_q.push_back(8'h00); m_unf = 1; end
            host_op(0, 1, 8'h00, 1);
        end else if (m_addr == 8'd1) begin
            exp_q.push_back(model_status());
            host_op(0, 1, 8'h00, 1);
        end else begin
            bus_exp_q.push_back({1'b0, m_addr, 8'h00});
            if (no_ack_mode) begin exp_q.push_back(8'hFF); m_tmo = 1; end
            host_op(0, 1, 8'h00, 0);
        end
    endtask

    task automatic check_flags();
        check("rx_empty", rx_empty, rx_model.size() == 0);
        check("tx_full", tx_full, tx_model.size() == TXD);
        if (rx_model.size() > 0) check("rx_head", rx_data, rx_model[0]);
    endtask

    task automatic rx_pop_op();
        @(posedge clk); #1;
        rx_pop = 1'b1;
        if (rx_model.size() > 0) rx_exp_q.push_back(rx_model.pop_front());
        @(posedge clk); #1;
        rx_pop = 1'b0;
        check_flags();
    endtask

    task automatic tx_push_op(input logic [7:0] d);
        @(posedge clk); #1;
        tx_data = d;
        tx_push = 1'b1;
        if (tx_model.size() < TXD) tx_model.push_back(d);
        @(posedge clk); #1;
        tx_push = 1'b0;
        check_flags();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] a;
        usb_write = 1'b1; usb_astb = 1'b1; usb_dstb = 1'b1; usb_db_i = 8'h00;
        rx_pop = 1'b0; tx_data = 8'h00; tx_push = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_usb_wait", usb_wait, 1);
        check("rst_usb_db_oe", usb_db_oe, 0);
        check("rst_usb_db_o", usb_db_o, 0);
        check("rst_bus_read", bus_read, 0);
        check("rst_bus_write", bus_write, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_tx_full", tx_full, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_wait_low", usb_wait, 0);

        // Address register write/readback
        host_addr_write(8'h05);
        host_addr_read();
        check("bus_addr_5", bus_addr, 8'h05);

        // RX FIFO ordering
        host_addr_write(8'h00);
        host_data_write(8'h11);
        host_data_write(8'h22);
        host_data_write(8'h33);
        check_flags();
        repeat (3) rx_pop_op();
        rx_pop_op();  // pop on empty is ignored

        // RX overflow, sticky flag and clear
        for (int i = 0; i < RXD; i++) host_data_write(8'($urandom));
        host_data_write(8'hAA);
        check_flags();
        host_addr_write(8'h01);
        host_data_read();
        host_data_write(8'h80);
        host_data_read();
        // Flush both FIFOs
        tx_push_op(8'h99);
        host_data_write(8'h40);
        check_flags();
        host_data_read();

        // TX FIFO and underflow
        tx_push_op(8'h5A);
        host_addr_write(8'h00);
        host_data_read();
        host_data_read();
        host_addr_write(8'h01);
        host_data_read();
        host_data_write(8'h80);
        for (int i = 0; i < TXD + 1; i++) tx_push_op(8'($urandom));
        host_addr_write(8'h00);
        for (int i = 0; i < TXD; i++) host_data_read();

        // Machine-bus cycles
        host_addr_write(8'h10);
        forced_lat = 2;
        host_data_write(8'h77);
        forced_rdata = 8'h3C;
        host_data_read();
        forced_lat = -1;
        forced_rdata = -1;

`ifdef EPP_BRIDGE_TIMEOUT_EN
        no_ack_mode = 1;
        host_data_read();
        no_ack_mode = 0;
        host_addr_write(8'h01);
        host_data_read();
        host_data_write(8'h80);
        host_data_read();
`endif

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0: begin
                    case ($urandom_range(0, 3))
                        0: a = 8'h00;
                        1: a = 8'h01;
                        default: a = 8'($urandom_range(2, 255));
                    endcase
                    host_addr_write(a);
                end
                1: host_addr_read();
                2, 3: host_data_write(8'($urandom));
                4: host_data_read();
                5: tx_push_op(8'($urandom));
                6: rx_pop_op();
                default: check_flags();
            endcase
        end

        repeat (5) @(posedge clk);
        #1;
        check("host_exp_drained", exp_q.size(), 0);
        check("rx_exp_drained", rx_exp_q.size(), 0);
        check("bus_exp_drained", bus_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
